// File: rtl/positaccum_encode_32.sv
// positaccum_encode_32
// Converts a raw accumulator value {sgn, scale[7:0], fraction, inf, zero}
// into a 32-bit posit (es=2) using a fixed 3-stage pipeline.
// There is no backpressure, and done is start delayed by 3 cycles.
// Optional macro POSIT_ENCODE_RNE_EN: when defined, the encoder uses
// round-to-nearest-even. When undefined, dropped bits are truncated.
// Latency is the same in both builds.
module positaccum_encode_32 #(
    parameter int FBITS_ACCUM                      = 32,
    parameter int POSIT_SERIALIZED_WIDTH_ACCUM_ES2 = FBITS_ACCUM + 11
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [POSIT_SERIALIZED_WIDTH_ACCUM_ES2-1:0] in1,
    input  logic                                        start,
    output logic [31:0]                                 result,
    output logic                                        done
);

    localparam int W   = POSIT_SERIALIZED_WIDTH_ACCUM_ES2;
    // Zero padding below the fraction. The regime shift is at most 31, so
    // no fraction bit can fall off the bottom of the template.
    localparam int PAD = 32;
    localparam int TW  = 4 + FBITS_ACCUM + PAD;

    // ---------------- input field split ----------------
    logic                    w_sgn;
    logic signed [7:0]       w_scale;
    logic [FBITS_ACCUM-1:0]  w_frac;
    logic                    w_inf;
    logic                    w_zero;

    assign w_sgn   = in1[W-1];
    assign w_scale = in1[W-2 -: 8];
    assign w_frac  = in1[FBITS_ACCUM+1:2];
    assign w_inf   = in1[1];
    assign w_zero  = in1[0];

    // ---------------- stage 1: k, e, regime run length ----------------
    logic signed [5:0] w_k;
    logic [5:0]        w_run;
    logic              w_sat_hi;
    logic              w_sat_lo;

    // scale >>> 2 on an 8-bit signed value is exactly its upper 6 bits.
    assign w_k      = w_scale[7:2];
    // Run length is k+1 ones for k>=0, and -k zeros for k<0.
    assign w_run    = w_k[5] ? (~w_k + 6'd1) : (w_k + 6'd1);
    assign w_sat_hi = (w_scale > 8'sd120);
    assign w_sat_lo = (w_scale < -8'sd120);

    logic                   r_s1_valid;
    logic                   r_s1_sgn;
    logic                   r_s1_inf;
    logic                   r_s1_zero;
    logic                   r_s1_sat_hi;
    logic                   r_s1_sat_lo;
    logic                   r_s1_kneg;
    logic [5:0]             r_s1_run;
    logic [1:0]             r_s1_e;
    logic [FBITS_ACCUM-1:0] r_s1_frac;

    // Stage 1 register: the decoded fields plus the regime run length.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_sgn    <= 1'b0;
            r_s1_inf    <= 1'b0;
            r_s1_zero   <= 1'b0;
            r_s1_sat_hi <= 1'b0;
            r_s1_sat_lo <= 1'b0;
            r_s1_kneg   <= 1'b0;
            r_s1_run    <= '0;
            r_s1_e      <= '0;
            r_s1_frac   <= '0;
        end else begin
            r_s1_valid  <= start;
            r_s1_sgn    <= w_sgn;
            r_s1_inf    <= w_inf;
            r_s1_zero   <= w_zero;
            r_s1_sat_hi <= w_sat_hi;
            r_s1_sat_lo <= w_sat_lo;
            r_s1_kneg   <= w_k[5];
            r_s1_run    <= w_run;
            r_s1_e      <= w_scale[1:0];
            r_s1_frac   <= w_frac;
        end
    end

    // ---------------- stage 2: build {regime, e, fraction} ----------------
    // The template starts with "10" (k>=0) or "01" (k<0). An arithmetic
    // right shift by run-1 copies the leading bit, which yields the whole
    // regime run plus its terminator. The shift amount is run-1 in both
    // cases.
    logic [1:0]           w_pat;
    logic [5:0]           w_shamt;
    logic signed [TW-1:0] w_tmpl;
    logic signed [TW-1:0] w_shifted;
    logic [30:0]          w_body;

    assign w_pat     = r_s1_kneg ? 2'b01 : 2'b10;
    assign w_shamt   = r_s1_run - 6'd1;
    assign w_tmpl    = {w_pat, r_s1_e, r_s1_frac, {PAD{1'b0}}};
    assign w_shifted = w_tmpl >>> w_shamt;
    assign w_body    = w_shifted[TW-1 -: 31];

`ifdef POSIT_ENCODE_RNE_EN
    logic w_guard;
    logic w_sticky;

    assign w_guard  = w_shifted[TW-32];
    assign w_sticky = |w_shifted[TW-33:0];
`else
    logic w_unused_tail;

    assign w_unused_tail = |w_shifted[TW-32:0];
`endif

    logic        r_s2_valid;
    logic        r_s2_sgn;
    logic        r_s2_inf;
    logic        r_s2_zero;
    logic        r_s2_sat_hi;
    logic        r_s2_sat_lo;
    logic [30:0] r_s2_body;
`ifdef POSIT_ENCODE_RNE_EN
    logic        r_s2_guard;
    logic        r_s2_sticky;
`endif

    // Stage 2 register: the 31-bit truncated magnitude and, with RNE, the round bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid  <= 1'b0;
            r_s2_sgn    <= 1'b0;
            r_s2_inf    <= 1'b0;
            r_s2_zero   <= 1'b0;
            r_s2_sat_hi <= 1'b0;
            r_s2_sat_lo <= 1'b0;
            r_s2_body   <= '0;
`ifdef POSIT_ENCODE_RNE_EN
            r_s2_guard  <= 1'b0;
            r_s2_sticky <= 1'b0;
`endif
        end else begin
            r_s2_valid  <= r_s1_valid;
            r_s2_sgn    <= r_s1_sgn;
            r_s2_inf    <= r_s1_inf;
            r_s2_zero   <= r_s1_zero;
            r_s2_sat_hi <= r_s1_sat_hi;
            r_s2_sat_lo <= r_s1_sat_lo;
            r_s2_body   <= w_body;
`ifdef POSIT_ENCODE_RNE_EN
            r_s2_guard  <= w_guard;
            r_s2_sticky <= w_sticky;
`endif
        end
    end

    // ---------------- stage 3: round, saturate, sign ----------------
    logic        w_inc;
    logic [31:0] w_sum;
    logic [30:0] w_mag;
    logic [31:0] w_result;

`ifdef POSIT_ENCODE_RNE_EN
    assign w_inc = r_s2_guard & (r_s2_sticky | r_s2_body[0]);
`else
    assign w_inc = 1'b0;
`endif

    // A carry out of the fraction ripples into the exponent and regime bits
    // through this integer increment.
    assign w_sum = {1'b0, r_s2_body} + {31'd0, w_inc};

    // Clamp to maxpos/minpos, apply the sign, then let zero/NaR override.
    always_comb begin
        w_mag = w_sum[30:0];
        if (r_s2_sat_hi || w_sum[31]) begin
            w_mag = 31'h7FFF_FFFF;
        end else if (r_s2_sat_lo || (w_sum[30:0] == 31'd0)) begin
            w_mag = 31'd1;
        end
        w_result = r_s2_sgn ? (32'd0 - {1'b0, w_mag}) : {1'b0, w_mag};
        if (r_s2_zero) begin
            w_result = '0;
        end else if (r_s2_inf) begin
            w_result = 32'h8000_0000;
        end
    end

    logic [31:0] r_result;
    logic        r_done;

    // Stage 3 register: drives the outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result <= '0;
            r_done   <= 1'b0;
        end else begin
            r_result <= w_result;
            r_done   <= r_s2_valid;
        end
    end

    assign result = r_result;
    assign done   = r_done;

endmodule

// File: tb/tb_positaccum_encode_32.sv
// Testbench for positaccum_encode_32.
// Uses a directed vector table, a randomized stream checked against a
// bit-list posit reference model, and a mid-stream reset sequence.
// Build with or without POSIT_ENCODE_RNE_EN to match the DUT.
module tb_positaccum_encode_32;

    localparam int FB = 32;
    localparam int W  = FB + 11;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  in1;
    logic          start;
    logic [31:0]   result;
    logic          done;

    int n_checks = 0;
    int n_fail   = 0;

    positaccum_encode_32 #(
        .FBITS_ACCUM                      (FB),
        .POSIT_SERIALIZED_WIDTH_ACCUM_ES2 (W)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .in1    (in1),
        .start  (start),
        .result (result),
        .done   (done)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish required finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit          sgn;
        int          scale;
        logic [31:0] frac;
        bit          inf;
        bit          zero;
        logic [31:0] exp;
        string       name;
    } vec_t;

    typedef struct {
        bit          v;
        logic [31:0] r;
    } exp_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit sgn, input int scale, input logic [31:0] frac,
                         input bit inf, input bit zero, input bit st);
        in1   = {sgn, 8'(scale), frac, inf, zero};
        start = st;
    endtask

    // Reference model. It writes the posit as a bit list (regime, exponent,
    // fraction), keeps the first 31 bits, and then rounds and clamps.
    function automatic logic [31:0] model(input bit sgn, input int scale, input logic [31:0] frac,
                                          input bit inf, input bit zero);
        bit     bits[$];
        longint mag;
        int     k;
        int     e;
`ifdef POSIT_ENCODE_RNE_EN
        bit     guard;
        bit     sticky;
`endif
        if (zero) return 32'h0000_0000;
        if (inf)  return 32'h8000_0000;
        if (scale > 120) begin
            mag = 64'h7FFF_FFFF;
        end else if (scale < -120) begin
            mag = 1;
        end else begin
            k = (scale >= 0) ? scale / 4 : (scale - 3) / 4;
            e = scale - 4 * k;
            if (k >= 0) begin
                for (int i = 0; i <= k; i++) bits.push_back(1'b1);
                bits.push_back(1'b0);
            end else begin
                for (int i = 0; i < -k; i++) bits.push_back(1'b0);
                bits.push_back(1'b1);
            end
            bits.push_back(e[1]);
            bits.push_back(e[0]);
            for (int i = 31; i >= 0; i--) bits.push_back(frac[i]);
            while (bits.size() < 33) bits.push_back(1'b0);
            mag = 0;
            for (int i = 0; i < 31; i++) mag = mag * 2 + longint'(bits[i]);
`ifdef POSIT_ENCODE_RNE_EN
            guard  = bits[31];
            sticky = 1'b0;
            for (int i = 32; i < bits.size(); i++) sticky |= bits[i];
            if (guard && (sticky || mag[0])) mag++;
`endif
            if (mag > 64'h7FFF_FFFF) mag = 64'h7FFF_FFFF;
            if (mag == 0) mag = 1;
        end
        if (sgn) mag = -mag;
        return mag[31:0];
    endfunction

    vec_t tbl[$];
    exp_t sb[$];

    initial begin
        exp_t        it;
        bit          sgn;
        bit          inf;
        bit          zero;
        bit          st;
        int          scale;
        logic [31:0] frac;
        logic signed [7:0] s8;

        rst   = 1'b1;
        in1   = '0;
        start = 1'b0;

        // ---- directed table ----
        tbl.push_back('{0,    0, 32'h0,         0, 0, 32'h4000_0000, "one"});
        tbl.push_back('{0,    1, 32'h0,         0, 0, 32'h4800_0000, "scale_p1"});
        tbl.push_back('{0,   -1, 32'h0,         0, 0, 32'h3800_0000, "scale_m1"});
        tbl.push_back('{1,    0, 32'h0,         0, 0, 32'hC000_0000, "neg_one"});
        tbl.push_back('{0,    5, 32'hDEAD_BEEF, 0, 1, 32'h0000_0000, "zero_flag"});
        tbl.push_back('{1,   -7, 32'h1234_5678, 1, 0, 32'h8000_0000, "inf_flag"});
        tbl.push_back('{0,    3, 32'h0,         1, 1, 32'h0000_0000, "zero_over_inf"});
        tbl.push_back('{0,  127, 32'h0,         0, 0, 32'h7FFF_FFFF, "maxpos_127"});
        tbl.push_back('{1, -128, 32'h0,         0, 0, 32'hFFFF_FFFF, "neg_minpos"});
        tbl.push_back('{0,  121, 32'h0,         0, 0, 32'h7FFF_FFFF, "sat_121"});
        tbl.push_back('{0, -121, 32'hFFFF_FFFF, 0, 0, 32'h0000_0001, "sat_m121"});
        tbl.push_back('{0,  120, 32'h0,         0, 0, 32'h7FFF_FFFF, "edge_120"});
        tbl.push_back('{0, -120, 32'h0,         0, 0, 32'h0000_0001, "edge_m120"});
        tbl.push_back('{1,  127, 32'h0,         0, 0, 32'h8000_0001, "neg_maxpos"});
`ifdef POSIT_ENCODE_RNE_EN
        tbl.push_back('{0,    0, 32'hFFFF_FFF0, 0, 0, 32'h4800_0000, "rne_carry"});
`else
        tbl.push_back('{0,    0, 32'hFFFF_FFF0, 0, 0, 32'h47FF_FFFF, "trunc_ones"});
`endif
        tbl.push_back('{0,    0, 32'h0000_0010, 0, 0, 32'h4000_0000, "tie_even"});

        // ---- reset state ----
        step();
        step();
        check("reset_result", result, 32'h0);
        check("reset_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        step();

        foreach (tbl[i]) begin
            drive(tbl[i].sgn, tbl[i].scale, tbl[i].frac, tbl[i].inf, tbl[i].zero, 1'b1);
            step();
            start = 1'b0;
            step();
            check({tbl[i].name, "_done_early"}, {31'd0, done}, 32'd0);
            step();
            check({tbl[i].name, "_done"}, {31'd0, done}, 32'd1);
            check(tbl[i].name, result, tbl[i].exp);
        end

        // ---- randomized back-to-back stream ----
        sb.delete();
        for (int c = 0; c < 403; c++) begin
            sgn  = 1'($urandom_range(0, 1));
            zero = ($urandom_range(0, 15) == 0);
            inf  = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) != 0) begin
                scale = $urandom_range(0, 60) - 30;
            end else begin
                s8    = 8'($urandom_range(0, 255));
                scale = s8;
            end
            frac = $urandom();
            if ($urandom_range(0, 3) == 0) frac = frac & 32'hFFFF_FFF0;
            st   = (c < 400) ? ($urandom_range(0, 4) != 0) : 1'b0;
            drive(sgn, scale, frac, inf, zero, st);
            it.v = st;
            it.r = model(sgn, scale, frac, inf, zero);
            sb.push_back(it);
            step();
            if (sb.size() >= 3) begin
                it = sb.pop_front();
                check("rand_done", {31'd0, done}, {31'd0, it.v});
                if (it.v) check("rand_result", result, it.r);
            end
        end
        start = 1'b0;
        step();
        step();

        // ---- reset in the middle of a burst ----
        for (int i = 0; i < 5; i++) begin
            drive(0, i, 32'h0, 0, 0, 1'b1);
            if (i == 2) begin
                rst = 1'b1;
                #1;
                check("rst_async_done", {31'd0, done}, 32'd0);
                check("rst_async_result", result, 32'h0);
            end
            step();
            if (i < 2) begin
                check("pre_rst_done", {31'd0, done}, 32'd0);
            end else begin
                check("in_rst_done", {31'd0, done}, 32'd0);
                check("in_rst_result", result, 32'h0);
            end
        end
        rst   = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_rst_idle_done", {31'd0, done}, 32'd0);
        end
        drive(0, 1, 32'h0, 0, 0, 1'b1);
        step();
        start = 1'b0;
        check("post_rst_lat1", {31'd0, done}, 32'd0);
        step();
        check("post_rst_lat2", {31'd0, done}, 32'd0);
        step();
        check("post_rst_done", {31'd0, done}, 32'd1);
        check("post_rst_result", result, 32'h4800_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
